// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t : FETCH (normal) / DRAIN (discarding responses to pre-redirect requests)
//   INSTR_W, ADDR_W : instruction and address widths
//   PC_STEP : byte distance between sequential fetches
//   DEFAULT_RESET_PC : default fetch address after reset
//   pc_next() : sequential successor of a fetch address (wraps modulo 2^32)
package mips_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO with registered storage and a head-of-queue read port.
// DEPTH need not be a power of two (pointers wrap explicitly).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               drop all entries (has priority over push/pop)
//   push, push_data     write an entry; accepted when not full, or when popping in the same cycle
//   pop                 remove the head entry; ignored when empty
//   head_data           current head entry (valid when !empty)
//   full, empty, count  occupancy status
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; clear wins over any push/pop
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s) && !clear;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; needs no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch front end: issues sequential word fetches over a req/rsp handshake,
// buffers returned words in order and presents {instr, pc+4} to the IF/ID register.
// A redirect flushes the buffer and discards every response to a request issued before it.
// Configuration macro: FETCHQ_BYPASS_EN -- when defined, a response arriving to an empty
// queue (nothing to drop, no redirect) is presented on out_* in the same cycle.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   redirect_valid, redirect_pc      restart fetch at redirect_pc
//   imem_req_valid/ready/addr        fetch request handshake
//   imem_rsp_valid/data              in-order responses, latency >= 1
//   out_valid/ready, out_instr, out_pc_incr   head entry toward IF/ID
//   busy                             requests outstanding or draining stale responses
module fetch_queue_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc_incr,
  output logic               busy
);

  localparam int unsigned QW      = INSTR_W + ADDR_W;
  localparam int unsigned Q_CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned O_CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned SUM_W   = ((Q_CNT_W > O_CNT_W) ? Q_CNT_W : O_CNT_W) + 1;

  fetch_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [O_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [QW-1:0]       q_head_s;
  logic                q_full_s, q_empty_s;
  logic [Q_CNT_W-1:0]  q_count_s;
  logic                q_push_s, q_pop_s;
  logic [ADDR_W-1:0]   af_head_s;
  logic                af_full_s, af_empty_s;
  logic [O_CNT_W-1:0]  outstanding_s;

  logic                rsp_fire_s;
  logic                rsp_keep_s;
  logic                req_fire_s;
  logic                bypass_s;
  logic [O_CNT_W-1:0]  outst_net_s;
  logic [SUM_W-1:0]    credit_sum_s;

  // Request credit, response acceptance and queue control
  always_comb begin
    // A response with nothing outstanding is a leftover from before reset: ignore it.
    rsp_fire_s   = imem_rsp_valid && !af_empty_s;
    outst_net_s  = outstanding_s - O_CNT_W'(rsp_fire_s);
    // Every outstanding request may return a word, so reserve a queue slot for each.
    credit_sum_s = SUM_W'(q_count_s) + SUM_W'(outstanding_s);
    imem_req_valid = !rst && !redirect_valid && !af_full_s && !q_full_s &&
                     (credit_sum_s < SUM_W'(DEPTH));
    req_fire_s   = imem_req_valid && imem_req_ready;
    rsp_keep_s   = rsp_fire_s && (drop_cnt_q == '0) && !redirect_valid;
`ifdef FETCHQ_BYPASS_EN
    bypass_s     = rsp_keep_s && q_empty_s;
`else
    bypass_s     = 1'b0;
`endif
    // A bypassed word taken by IF/ID this cycle must not also be queued.
    q_push_s     = rsp_keep_s && !(bypass_s && out_ready);
    q_pop_s      = out_ready && !q_empty_s;
  end

  // Output select: queue head, or the live response while bypassing
  always_comb begin
    if (bypass_s) begin
      out_valid   = 1'b1;
      out_instr   = imem_rsp_data;
      out_pc_incr = pc_next(af_head_s);
    end else begin
      out_valid   = !q_empty_s;
      out_instr   = q_head_s[QW-1 -: INSTR_W];
      out_pc_incr = q_head_s[ADDR_W-1:0];
    end
  end

  // Next fetch address, drop count and drain state
  always_comb begin
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (req_fire_s) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    // On redirect every request still in flight belongs to the abandoned path.
    if (redirect_valid) begin
      drop_cnt_d = outst_net_s;
    end else if (rsp_fire_s && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - O_CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    case (state_q)
      FETCH: begin
        if (redirect_valid && (outst_net_s != '0)) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          state_d = (outst_net_s != '0) ? DRAIN : FETCH;
        end else if (drop_cnt_d == '0) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign imem_req_addr = fetch_pc_q;
  assign busy          = (outstanding_s != '0) || (state_q == DRAIN);

  // Instruction queue: {instr, fetch address + 4}
  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (q_push_s),
    .push_data ({imem_rsp_data, pc_next(af_head_s)}),
    .pop       (q_pop_s),
    .head_data (q_head_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s)
  );

  // In-flight address FIFO: its occupancy is the outstanding-request count
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTST)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire_s),
    .push_data (fetch_pc_q),
    .pop       (rsp_fire_s),
    .head_data (af_head_s),
    .full      (af_full_s),
    .empty     (af_empty_s),
    .count     (outstanding_s)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Self-checking bench: a transaction-level memory and fetch model (queues of addresses)
// checked against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc_incr;
  logic        busy;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_incr    (out_pc_incr),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          pre;   // issued before the last reset
  } mem_ent_t;

  mem_ent_t    mem_pending[$];
  mem_ent_t    rsp_ent;
  logic [31:0] m_q[$];        // fetch addresses of buffered words
  logic [31:0] del_log[$];    // out_pc_incr of every word taken by IF/ID
  int          m_outst, m_stale;
  logic [31:0] m_req_pc, m_del_pc;
  int          cyc, last_due;
  int          n_checks, n_pass;

  bit          drv_rst, drv_ready, drv_out_ready, drv_redirect;
  logic [31:0] drv_redirect_pc;
  int          lat_min, lat_max;
  bit          rsp_now;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, compare after settling, then advance the model.
  task automatic step();
    bit          real_rsp, byp, exp_ov, consume, fire, exp_req;
    logic [31:0] exp_pc;
    int          lat, due;
    @(negedge clk);
    rst            = drv_rst;
    imem_req_ready = drv_ready;
    out_ready      = drv_out_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    rsp_now = (mem_pending.size() != 0) && (mem_pending[0].due <= cyc);
    if (rsp_now) rsp_ent = mem_pending[0];
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(rsp_ent.addr) : 32'hDEAD_BEEF;
    #1;
    if (drv_rst) begin
      check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
      if (rsp_now) void'(mem_pending.pop_front());
      foreach (mem_pending[i]) mem_pending[i].pre = 1'b1;
      m_q.delete();
      m_outst  = 0;
      m_stale  = 0;
      m_req_pc = RESET_PC;
      m_del_pc = RESET_PC;
    end else begin
      real_rsp = rsp_now && !rsp_ent.pre && (m_outst != 0);
      byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      byp = real_rsp && (m_stale == 0) && !drv_redirect && (m_q.size() == 0);
`endif
      exp_ov  = (m_q.size() != 0) || byp;
      exp_pc  = (m_q.size() != 0) ? m_q[0] : rsp_ent.addr;
      exp_req = !drv_redirect && (m_outst < MAX_OUTST) && ((m_q.size() + m_outst) < DEPTH);
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      check("req_addr", imem_req_addr, m_req_pc);
      check("busy", {31'd0, busy}, {31'd0, (m_outst != 0) || (m_stale != 0)});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        check("out_pc_incr", out_pc_incr, exp_pc + 32'd4);
        check("out_instr", out_instr, mem_word(exp_pc));
      end
      consume = exp_ov && drv_out_ready;
      if (consume) begin
        check("deliver_order", out_pc_incr, m_del_pc + 32'd4);
        del_log.push_back(out_pc_incr);
        m_del_pc = m_del_pc + 32'd4;
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      if (rsp_now) begin
        void'(mem_pending.pop_front());
        if (real_rsp) begin
          m_outst--;
          if (m_stale != 0) m_stale--;
          else if (!drv_redirect && !(byp && consume)) m_q.push_back(rsp_ent.addr);
        end
      end
      if (drv_redirect) begin
        m_stale  = m_outst;
        m_q.delete();
        m_req_pc = drv_redirect_pc;
        m_del_pc = drv_redirect_pc;
      end
      fire = imem_req_valid && drv_ready;
      if (fire) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_pending.push_back('{addr: imem_req_addr, due: due, pre: 1'b0});
        m_outst++;
        m_req_pc = m_req_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Run until one more word is delivered, bounded by limit cycles.
  task automatic wait_deliver(input string name, input int limit);
    int n0;
    n0 = del_log.size();
    for (int i = 0; i < limit && del_log.size() == n0; i++) step();
    check(name, {31'd0, del_log.size() > n0}, 32'd1);
  endtask

  task automatic wait_two_outst(input string name);
    for (int i = 0; i < 30 && m_outst != 2; i++) step();
    check(name, m_outst, 32'd2);
  endtask

  initial begin
    int n0;
    n_checks = 0; n_pass = 0; cyc = 0; last_due = -1;
    drv_rst = 1'b1; drv_ready = 1'b0; drv_out_ready = 1'b0;
    drv_redirect = 1'b0; drv_redirect_pc = 32'h0;
    lat_min = 1; lat_max = 1;
    rst = 1'b1; imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    step(); step();

    // Reset state and sequential streaming at one word per cycle
    drv_rst = 1'b0; drv_ready = 1'b1; drv_out_ready = 1'b1;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    repeat (9) step();
    n0 = del_log.size();
    repeat (20) step();
    check("throughput_20", del_log.size() - n0, 32'd20);
    check("first_pc_incr0", del_log[0], 32'h4);
    check("first_pc_incr1", del_log[1], 32'h8);
    check("first_pc_incr2", del_log[2], 32'hC);

    // IF/ID stalled: queue fills to exactly DEPTH and requests stop
    drv_out_ready = 1'b0;
    repeat (10) step();
    check("bp_model_occupancy", m_q.size(), DEPTH);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    drv_out_ready = 1'b1;
    repeat (10) step();

    // Latency 3 with two outstanding, redirect to 0x40
    lat_min = 3; lat_max = 3;
    wait_two_outst("s3_two_outstanding");
    drv_redirect = 1'b1; drv_redirect_pc = 32'h40;
    step();
    drv_redirect = 1'b0;
    step();
    check("s3_out_valid_after_redirect", {31'd0, out_valid}, 32'd0);
    check("s3_busy_draining", {31'd0, busy}, 32'd1);
    wait_deliver("s3_deliver_timeout", 40);
    check("s3_first_pc_incr", del_log[del_log.size()-1], 32'h44);

    // Redirect coinciding with a response and an IF/ID handshake
    lat_min = 1; lat_max = 1;
    repeat (12) step();
    drv_redirect = 1'b1; drv_redirect_pc = 32'h100;
    step();
    check("s4_handshake_in_redirect", {31'd0, out_valid}, 32'd1);
    drv_redirect = 1'b0;
    step();
    check("s4_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("s4_busy_after", {31'd0, busy}, 32'd0);
    wait_deliver("s4_deliver_timeout", 40);
    check("s4_first_pc_incr", del_log[del_log.size()-1], 32'h104);

    // Fetch address wrap at the top of the address space
    drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFFC;
    step();
    drv_redirect = 1'b0;
    wait_deliver("s5_deliver_timeout0", 40);
    check("s5_wrap_pc_incr0", del_log[del_log.size()-1], 32'h0000_0000);
    wait_deliver("s5_deliver_timeout1", 40);
    check("s5_wrap_pc_incr1", del_log[del_log.size()-1], 32'h0000_0004);

    // Reset with two outstanding; stale responses must be ignored afterwards
    lat_min = 3; lat_max = 3;
    wait_two_outst("s6_two_outstanding");
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0; drv_ready = 1'b0;
    for (int i = 0; i < 20 && mem_pending.size() != 0; i++) step();
    check("s6_stale_drained", mem_pending.size(), 32'd0);
    check("s6_out_valid", {31'd0, out_valid}, 32'd0);
    drv_ready = 1'b1;
    wait_deliver("s6_deliver_timeout", 40);
    check("s6_first_pc_incr", del_log[del_log.size()-1], RESET_PC + 32'd4);

    // Randomized traffic
    lat_min = 1; lat_max = 4;
    n0 = del_log.size();
    repeat (3000) begin
      drv_ready     = ($urandom_range(0, 3) != 0);
      drv_out_ready = ($urandom_range(0, 9) < 7);
      drv_redirect  = ($urandom_range(0, 31) == 0);
      drv_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                   : ($urandom() & 32'hFFFF_FFFC);
      step();
    end
    drv_redirect = 1'b0;
    check("random_progress", {31'd0, del_log.size() > n0 + 100}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
